serial_to_parallel_demux: RTL and testbench
===========================================

// Module: serial_to_parallel_demux
// PURPOSE
//  - Receive end of the 8-way bit-select path: takes a serial bit stream and demuxes each bit
//    into slot sel[2:0] of a WIDTH-bit assembly register; a 3-bit slot counter drives sel.
//  - Presents each completed word on a valid/ready output port; one word of output buffering
//    lets assembly of the next word overlap with a stalled consumer.
//  - Sits between a bit-serial link and word-wide datapath logic.
// PARAMETERS
//  - WIDTH    8  word width in bits; power of 2, >= 2
//  - SEL_W    3  localparam = $clog2(WIDTH); width of slot counter
// PORTS
//  - clk        in   1      rising-edge clock
//  - rst        in   1      synchronous active-high reset
//  - flush      in   1      discard partial word, slot counter -> 0
//  - in_valid   in   1      in_bit valid this cycle
//  - in_bit     in   1      serial data bit
//  - in_ready   out  1      block accepts in_bit this cycle
//  - out_data   out  WIDTH  assembled word
//  - out_valid  out  1      out_data valid
//  - out_ready  in   1      consumer accepts out_data
//  - slot       out  SEL_W  current demux select (index of next bit)
//  - out_perr   out  1      parity error for out_data (PARITY_EN only; tied 0 otherwise)
// BEHAVIOUR
//  - Reset values: in_ready=1, out_data=0, out_valid=0, slot=0, out_perr=0; assembly reg=0.
//  - Accept = in_valid & in_ready. On accept: asm[slot] <= in_bit; slot <= slot+1 (LSB first).
//  - Slot wraps WIDTH-1 -> 0. Accept at slot==WIDTH-1 completes the word: the full word (with
//    the completing bit merged) loads out_data, out_valid=1 next cycle. Latency: last bit to
//    out_valid = 1 cycle.
//  - Output handshake: out_valid & out_ready clears out_valid; out_data held stable while
//    out_valid & !out_ready.
//  - Backpressure: in_ready = !(slot==WIDTH-1 & out_valid & !out_ready). Completion and
//    out_ready in the same cycle: old word retires, new word loads, out_valid stays 1.
//  - Non-completing bits are always accepted, including while the output stalls.
//  - flush: slot<=0, asm<=0; in_bit that cycle discarded even if in_valid; out_valid/out_data
//    unaffected. flush has priority over accept; rst over everything.
//  - Reset mid-word: partial word and pending output lost, no out_valid emitted.
//  - No combinational path from in_* to out_*; in_ready depends only on regs + out_ready.
// CONFIGURATION
//  - Macro PARITY_EN.
//  - Defined: frame = WIDTH data bits + 1 even-parity bit; slot counts 0..WIDTH (SEL_W+1 bits
//    internally, slot port shows low SEL_W bits); completion on parity bit;
//    out_perr = ^{data,parity}, valid with out_valid, reset 0; in_ready stall condition uses
//    the parity slot.
//  - Undefined: behaviour as above; out_perr tied 0.
// STRUCTURE
//  - Shared package: SEL_W derivation, reset constants, PARITY_EN-dependent FRAME_LEN.
//  - One sub-module: bit_slot_demux (combinational 1-to-WIDTH decoder: sel, bit ->
//    per-slot write enable); the counter and buffer stay in the top.
// TESTING
//  - Reset: rst=1 2 cycles -> out_valid=0, slot=0, in_ready=1, out_data=8'h00.
//  - Stream bits 1,0,1,0,0,1,0,1 (LSB first), out_ready=1 -> out_data=8'hA5, out_valid 1 cycle
//    after the 8th bit, then slot=0.
//  - out_ready=0, send 8'h3C then 7 bits of 8'hC3 -> 8'h3C held, in_ready=0 at slot 7;
//    raise out_ready -> 8'h3C retires, 8'hC3 completes, next word valid.
//  - Send 3 bits, assert flush with in_valid=1, then 8 bits of 8'hFF -> out_data=8'hFF,
//    flushed bits absent.
//  - Back-to-back 16 bits, out_ready=1 -> 8'h12 then 8'h34, no gap, in_ready constant 1.
//  - PARITY_EN: frame 8'h07 + parity 1 -> out_perr=0; parity 0 -> out_perr=1.

Source files
------------

// File: rtl/serial_to_parallel_demux_pkg.sv
// Shared constants for the serial-to-parallel demux: slot width derivation, reset values, frame length.
// Frame length grows by one parity bit when PARITY_EN is defined.
package serial_to_parallel_demux_pkg;

    localparam int DEF_WIDTH = 8;

`ifdef PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam logic RST_IN_READY  = 1'b1;
    localparam logic RST_OUT_VALID = 1'b0;
    localparam logic RST_OUT_PERR  = 1'b0;

    function automatic int sel_w(input int width);
        return $clog2(width);
    endfunction

    // Bits per frame on the serial link, including the optional parity bit.
    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/serial_to_parallel_demux_bit_slot_demux.sv
// Combinational 1-to-WIDTH slot decoder: steers one serial bit into a set or clear
// enable for the selected slot of the assembly register.
module bit_slot_demux #(
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             din,
    output logic [WIDTH-1:0] set_en,
    output logic [WIDTH-1:0] clr_en
);

    always_comb begin
        set_en = '0;
        clr_en = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (en && (sel == SEL_W'(i))) begin
                set_en[i] = din;
                clr_en[i] = !din;
            end
        end
    end

endmodule

// File: rtl/serial_to_parallel_demux.sv
// Serial bit stream -> WIDTH-bit words, LSB first, with one word of output buffering.
// Optional PARITY_EN macro adds an even-parity bit per frame and drives out_perr.
import serial_to_parallel_demux_pkg::*;

module serial_to_parallel_demux #(
    parameter int WIDTH = DEF_WIDTH,
    localparam int SEL_W = sel_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] slot,
    output logic             out_perr
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, and the data under a raised valid stays stable until taken.

    localparam int CNT_W = SEL_W + PARITY_BITS;
    localparam int FRAME = frame_len(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] asm_next;
    logic [WIDTH-1:0] set_en;
    logic [WIDTH-1:0] clr_en;
    logic             at_last;
    logic             accept;
    logic             complete;
    logic             retire;
    logic             data_en;

    always_comb begin
        at_last  = (cnt_q == LAST);
        // Only the completing bit can stall, and only when the buffered word is not leaving.
        in_ready = !(at_last && out_valid && !out_ready);
        accept   = in_valid && in_ready && !flush;
        complete = accept && at_last;
        retire   = out_valid && out_ready;
`ifdef PARITY_EN
        data_en  = accept && !cnt_q[SEL_W];
`else
        data_en  = accept;
`endif
        asm_next = (asm_q & ~clr_en) | set_en;
    end

    bit_slot_demux #(.WIDTH(WIDTH)) u_demux (
        .en     (data_en),
        .sel    (cnt_q[SEL_W-1:0]),
        .din    (in_bit),
        .set_en (set_en),
        .clr_en (clr_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            asm_q     <= '0;
            out_data  <= '0;
            out_valid <= RST_OUT_VALID;
        end else begin
            if (flush) begin
                cnt_q <= '0;
                asm_q <= '0;
            end else if (accept) begin
                if (at_last) begin
                    cnt_q <= '0;
                    asm_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    asm_q <= asm_next;
                end
            end

            // A completing word may replace a retiring one in the same cycle.
            if (complete) begin
                out_data  <= asm_next;
                out_valid <= 1'b1;
            end else if (retire) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_EN
    logic perr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= RST_OUT_PERR;
        end else if (complete) begin
            perr_q <= ^{asm_next, in_bit};
        end
    end

    assign out_perr = perr_q;
`else
    assign out_perr = RST_OUT_PERR;
`endif

    assign slot = cnt_q[SEL_W-1:0];

endmodule

// File: tb/tb_serial_to_parallel_demux.sv
// Bench for serial_to_parallel_demux: directed vector table, corner sequences, and
// randomized traffic against a queue-based frame model.
module tb_serial_to_parallel_demux;
    import serial_to_parallel_demux_pkg::*;

    localparam int W  = 8;
    localparam int SW = 3;
    localparam int FL = frame_len(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [SW-1:0] slot;
    logic          out_perr;

    serial_to_parallel_demux #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot),
        .out_perr  (out_perr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the frame in progress plus the single output buffer.
    bit           m_bits[$];
    bit           m_ov = 1'b0;
    logic [W-1:0] m_od = '0;
    bit           m_perr = 1'b0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        bit           r, f, iv, ib, ordy;
        bit           e_ir, e_ov;
        logic [W-1:0] e_od;
        logic [SW-1:0] e_slot;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input bit r, input bit f, input bit iv, input bit ib, input bit ordy);
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_bit    = ib;
        out_ready = ordy;
        #1;
    endtask

    // Compare current outputs with the model, then advance the model across the next edge.
    task automatic model_step();
        bit           exp_ready;
        bit           done;
        bit           p;
        logic [W-1:0] w;
        exp_ready = !((m_bits.size() == FL - 1) && m_ov && !out_ready);
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("slot", slot, m_bits.size() % W);
        chk("out_perr", out_perr, m_perr);
        if (rst) begin
            m_bits.delete();
            exp_q.delete();
            m_ov = 1'b0;
            m_od = '0;
            m_perr = 1'b0;
            return;
        end
        if (m_ov && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                chk("sb_word", out_data, exp_q.pop_front());
            end
        end
        done = 1'b0;
        if (flush) begin
            m_bits.delete();
        end else if (in_valid && exp_ready) begin
            m_bits.push_back(in_bit);
            if (m_bits.size() == FL) begin
                w = '0;
                p = 1'b0;
                for (int i = 0; i < FL; i++) begin
                    p ^= m_bits[i];
                    if (i < W) w[i] = m_bits[i];
                end
                m_od = w;
                m_ov = 1'b1;
`ifdef PARITY_EN
                m_perr = p;
`else
                m_perr = 1'b0;
`endif
                exp_q.push_back(w);
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (!done && m_ov && out_ready) m_ov = 1'b0;
    endtask

    task automatic bit_cycle(input bit iv, input bit ib, input bit ordy);
        apply(1'b0, 1'b0, iv, ib, ordy);
        model_step();
    endtask

    task automatic add(input bit r, input bit f, input bit iv, input bit ib, input bit ordy,
                       input bit e_ir, input bit e_ov, input logic [W-1:0] e_od,
                       input logic [SW-1:0] e_slot);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.ib = ib; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_slot = e_slot;
        vecs.push_back(v);
    endtask

    task automatic add_bits(input logic [W-1:0] d, input int n, input bit ordy,
                            input bit e_ov, input logic [W-1:0] e_od);
        for (int k = 0; k < n; k++) add(0, 0, 1, d[k], ordy, 1, e_ov, e_od, SW'(k));
    endtask

    initial begin
`ifndef PARITY_EN
        // Reset, A5 stream, stalled output with overlapping C3 assembly.
        add(1, 0, 0, 0, 0, 1, 0, 8'h00, 0);
        add(1, 0, 0, 0, 0, 1, 0, 8'h00, 0);
        add_bits(8'hA5, 8, 1, 0, 8'h00);
        add(0, 0, 0, 0, 0, 1, 1, 8'hA5, 0);
        add(0, 0, 0, 0, 1, 1, 1, 8'hA5, 0);
        add(0, 0, 0, 0, 1, 1, 0, 8'hA5, 0);
        add_bits(8'h3C, 8, 0, 0, 8'hA5);
        add_bits(8'hC3, 7, 0, 1, 8'h3C);
        add(0, 0, 1, 1, 0, 0, 1, 8'h3C, 7);
        add(0, 0, 1, 1, 1, 1, 1, 8'h3C, 7);
        add(0, 0, 0, 0, 0, 1, 1, 8'hC3, 0);
        add(0, 0, 0, 0, 1, 1, 1, 8'hC3, 0);
        add(0, 0, 0, 0, 1, 1, 0, 8'hC3, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].ib, vecs[i].ordy);
            chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
            chk($sformatf("vec%0d_slot", i), slot, vecs[i].e_slot);
            model_step();
        end

        // Flush mid-word: three bits, flush with in_valid high, then a full FF word.
        bit_cycle(1, 1, 1);
        bit_cycle(1, 0, 1);
        bit_cycle(1, 1, 1);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        model_step();
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            if (k == 0) chk("flush_slot", slot, 0);
            chk("flush_no_early_valid", out_valid, 0);
            model_step();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush_word_valid", out_valid, 1);
        chk("flush_word_data", out_data, 8'hFF);
        model_step();

        // Back-to-back words 12 then 34 with a ready consumer.
        for (int k = 0; k < 16; k++) begin
            logic [15:0] d;
            d = 16'h3412;
            apply(1'b0, 1'b0, 1'b1, d[k], 1'b1);
            chk("b2b_in_ready", in_ready, 1);
            if (k == 8) begin
                chk("b2b_first_valid", out_valid, 1);
                chk("b2b_first_data", out_data, 8'h12);
            end
            model_step();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second_data", out_data, 8'h34);
        chk("b2b_slot", slot, 0);
        model_step();
`else
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        model_step();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("par_rst_perr", out_perr, 0);
        model_step();
        for (int n = 0; n < 2; n++) begin
            logic [8:0] fr;
            fr = (n == 0) ? 9'h107 : 9'h007;
            for (int k = 0; k < 9; k++) begin
                apply(1'b0, 1'b0, 1'b1, fr[k], 1'b1);
                chk("par_in_ready", in_ready, 1);
                model_step();
            end
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("par_valid", out_valid, 1);
            chk("par_data", out_data, 8'h07);
            chk("par_perr", out_perr, (n == 0) ? 0 : 1);
            model_step();
        end
`endif

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            bit r, f, iv, ib, ordy;
            r    = ($urandom_range(0, 199) == 0);
            f    = ($urandom_range(0, 29) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ib   = 1'($urandom);
            ordy = ($urandom_range(0, 9) < 6);
            apply(r, f, iv, ib, ordy);
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
